// File: rtl/bme_i2c_seq.sv
// bme_i2c_seq: fetches 9-bit microcode words from a ROM and drives an I2C byte master.
// Optional build macro I2C_SEQ_NACK_ABORT_EN: a NACKed WRITE aborts the sequence with error.
module bme_i2c_seq #(
  parameter logic [8:0] START_ADDR = 9'd0,
  parameter int         WAIT_UNIT  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [8:0] rom_ad,
  output logic       rom_ce,
  output logic       rom_oce,
  input  logic [8:0] rom_dout,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_op,
  output logic [7:0] cmd_data,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_data,
  input  logic       rsp_nack,
  output logic       rd_valid,
  output logic [7:0] rd_idx,
  output logic [7:0] rd_data
);

  // state    | meaning
  // IDLE     | waiting for start
  // FETCH    | rom_ce asserted for the current rom_ad
  // LATCH    | capture rom_dout, advance rom_ad
  // DECODE   | interpret captured word
  // ISSUE    | present command until cmd_ready
  // WAIT_RSP | wait for byte master response to WRITE/READ
  // DELAY    | WAIT down-counter running
  // ERR_STOP | present STOP after an error, then IDLE
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_ISSUE, S_WAIT_RSP, S_DELAY, S_ERR_STOP
  } state_t;

  localparam logic [2:0]  OP_START = 3'd0;
  localparam logic [2:0]  OP_WRITE = 3'd1;
  localparam logic [2:0]  OP_RACK  = 3'd2;
  localparam logic [2:0]  OP_RNACK = 3'd3;
  localparam logic [2:0]  OP_STOP  = 3'd4;
  localparam logic [15:0] WU16     = 16'(WAIT_UNIT);

  state_t      state_q, state_d;
  logic [8:0]  rom_ad_q, rom_ad_d;
  logic [8:0]  word_q, word_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  data_q, data_d;
  logic [4:0]  nrd_q, nrd_d;
  logic [15:0] dly_q, dly_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        rdv_q, rdv_d;
  logic [7:0]  rd_idx_q, rd_idx_d;
  logic [7:0]  rd_cnt_q, rd_cnt_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        nack_abort;

`ifdef I2C_SEQ_NACK_ABORT_EN
  assign nack_abort = rsp_nack;
`else
  logic unused_nack;
  assign unused_nack = rsp_nack;
  assign nack_abort  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rom_ad_q  <= START_ADDR;
      word_q    <= 9'd0;
      op_q      <= 3'd0;
      data_q    <= 8'd0;
      nrd_q     <= 5'd0;
      dly_q     <= 16'd0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      rdv_q     <= 1'b0;
      rd_idx_q  <= 8'd0;
      rd_cnt_q  <= 8'd0;
      rd_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      rom_ad_q  <= rom_ad_d;
      word_q    <= word_d;
      op_q      <= op_d;
      data_q    <= data_d;
      nrd_q     <= nrd_d;
      dly_q     <= dly_d;
      err_q     <= err_d;
      done_q    <= done_d;
      rdv_q     <= rdv_d;
      rd_idx_q  <= rd_idx_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rom_ad_d  = rom_ad_q;
    word_d    = word_q;
    op_d      = op_q;
    data_d    = data_q;
    nrd_d     = nrd_q;
    dly_d     = dly_q;
    err_d     = err_q;
    done_d    = 1'b0;
    rdv_d     = 1'b0;
    rd_idx_d  = rd_idx_q;
    rd_cnt_d  = rd_cnt_q;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rom_ad_d = START_ADDR;
          err_d    = 1'b0;
          rd_idx_d = 8'd0;
          rd_cnt_d = 8'd0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        word_d   = rom_dout;
        rom_ad_d = rom_ad_q + 9'd1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (!word_q[8]) begin
          op_d    = OP_WRITE;
          data_d  = word_q[7:0];
          state_d = S_ISSUE;
        end else begin
          case (word_q[7:5])
            3'b000: begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
            3'b001: begin
              op_d    = OP_START;
              state_d = S_ISSUE;
            end
            3'b010: begin
              op_d    = OP_STOP;
              state_d = S_ISSUE;
            end
            3'b011: begin
              // nrd counts bytes still to read after the one being issued
              nrd_d   = word_q[4:0];
              op_d    = (word_q[4:0] == 5'd0) ? OP_RNACK : OP_RACK;
              state_d = S_ISSUE;
            end
            3'b100: begin
              dly_d   = ({11'd0, word_q[4:0]} + 16'd1) * WU16 - 16'd1;
              state_d = S_DELAY;
            end
            3'b101: begin
              rom_ad_d = START_ADDR;
              state_d  = S_FETCH;
            end
            default: begin
              err_d   = 1'b1;
              op_d    = OP_STOP;
              state_d = S_ERR_STOP;
            end
          endcase
        end
      end
      S_ISSUE: begin
        if (cmd_ready)
          state_d = (op_q == OP_START || op_q == OP_STOP) ? S_FETCH : S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (rsp_valid) begin
          if (op_q == OP_WRITE) begin
            if (nack_abort) begin
              err_d   = 1'b1;
              op_d    = OP_STOP;
              state_d = S_ERR_STOP;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            rdv_d     = 1'b1;
            rd_data_d = rsp_data;
            rd_idx_d  = rd_cnt_q;
            rd_cnt_d  = rd_cnt_q + 8'd1;
            if (nrd_q == 5'd0) begin
              state_d = S_FETCH;
            end else begin
              nrd_d   = nrd_q - 5'd1;
              op_d    = (nrd_q == 5'd1) ? OP_RNACK : OP_RACK;
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_DELAY: begin
        if (dly_q == 16'd0) state_d = S_FETCH;
        else dly_d = dly_q - 16'd1;
      end
      S_ERR_STOP: begin
        if (cmd_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign error     = err_q;
  assign rom_ad    = rom_ad_q;
  assign rom_ce    = (state_q == S_FETCH);
  assign rom_oce   = 1'b1;
  assign cmd_valid = (state_q == S_ISSUE) || (state_q == S_ERR_STOP);
  assign cmd_op    = op_q;
  assign cmd_data  = data_q;
  assign rd_valid  = rdv_q;
  assign rd_idx    = rd_idx_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_bme_i2c_seq.sv
// Self-checking bench for bme_i2c_seq: table vectors, hand sequences and random microcode
// programs checked against a program-level interpreter of the microcode.
module tb_bme_i2c_seq;
  localparam logic [8:0] SA = 9'h1FC;
  localparam int         WU = 4;

  logic clk = 1'b0;
  logic rst_n, start;
  logic busy, done, error, rom_ce, rom_oce, cmd_valid, cmd_ready;
  logic rsp_valid, rsp_nack, rd_valid;
  logic [8:0] rom_ad, rom_dout;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data, rsp_data, rd_idx, rd_data;

  always #5 clk = ~clk;

  bme_i2c_seq #(.START_ADDR(SA), .WAIT_UNIT(WU)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_dout(rom_dout),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data));

  int checks = 0, failures = 0;
  logic [8:0]  rom_mem [512];
  logic [10:0] cmd_log[$], exp_cmd[$];
  logic [15:0] rd_log[$], exp_rd[$];
  logic [7:0]  slave_q[$];
  int  done_cnt, busy_cyc, stab_err, stall_cyc, hold_low;
  bit  mute, spurious, nack_cfg, exp_done, exp_err;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ROM and byte-master model, plus output monitor, all on the falling edge
  initial begin
    bit pce = 0, prev_wait = 0, pend_rd = 0;
    logic [8:0] pad = '0;
    logic [2:0] prev_op = '0;
    logic [7:0] prev_data = '0;
    int pend = 0;
    cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; rsp_data = 0; rom_dout = 0;
    forever begin
      @(negedge clk);
      if (rd_valid) rd_log.push_back({rd_idx, rd_data});
      if (done) done_cnt++;
      if (busy) busy_cyc++;
      if (prev_wait && (!cmd_valid || cmd_op != prev_op || (prev_op == 3'd1 && cmd_data != prev_data)))
        stab_err++;
      if (pce) rom_dout = rom_mem[pad];
      pce = rom_ce; pad = rom_ad;
      rsp_valid = 0; rsp_nack = 0;
      if (!rst_n) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rsp_valid = 1;
          if (pend_rd) begin
            rsp_data = 8'hEE;
            if (slave_q.size() > 0) rsp_data = slave_q.pop_front();
          end else begin
            rsp_data = 8'($urandom);
            rsp_nack = nack_cfg;
          end
        end
      end else if (spurious && $urandom_range(0, 7) == 0) begin
        rsp_valid = 1; rsp_data = 8'($urandom); rsp_nack = 1'($urandom);
      end
      cmd_ready = (hold_low > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (cmd_valid && hold_low > 0) hold_low--;
      if (cmd_valid && !cmd_ready) stall_cyc++;
      if (cmd_valid && cmd_ready && rst_n) begin
        cmd_log.push_back({cmd_op, cmd_data});
        if (cmd_op inside {3'd1, 3'd2, 3'd3} && !mute) begin
          pend = $urandom_range(1, 3);
          pend_rd = (cmd_op != 3'd1);
        end
      end
      prev_wait = cmd_valid && !cmd_ready; prev_op = cmd_op; prev_data = cmd_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [8:0] w[$]);
    for (int j = 0; j < w.size(); j++) rom_mem[(int'(SA) + j) % 512] = w[j];
  endtask

  // Interprets a program the way the microcode is defined (no LOOP support needed here)
  task automatic model(input logic [8:0] w[$], input logic [7:0] sd[$], input bit nack);
    int k = 0, idx = 0;
    logic [8:0] x;
    exp_cmd.delete(); exp_rd.delete(); exp_done = 0; exp_err = 0;
    for (int i = 0; i < w.size(); i++) begin
      x = w[i];
      if (!x[8]) begin
        exp_cmd.push_back({3'd1, x[7:0]});
`ifdef I2C_SEQ_NACK_ABORT_EN
        if (nack) begin exp_cmd.push_back({3'd4, 8'h00}); exp_err = 1; return; end
`endif
      end else begin
        case (x[7:5])
          3'd0: begin exp_done = 1; return; end
          3'd1: exp_cmd.push_back({3'd0, 8'h00});
          3'd2: exp_cmd.push_back({3'd4, 8'h00});
          3'd3: for (int j = 0; j <= int'(x[4:0]); j++) begin
            exp_cmd.push_back({(j == int'(x[4:0])) ? 3'd3 : 3'd2, 8'h00});
            exp_rd.push_back({8'(idx), sd[k]});
            k++; idx++;
          end
          3'd4: ;
          default: begin exp_cmd.push_back({3'd4, 8'h00}); exp_err = 1; return; end
        endcase
      end
    end
  endtask

  task automatic clear_logs();
    cmd_log.delete(); rd_log.delete();
    done_cnt = 0; busy_cyc = 0; stab_err = 0; stall_cyc = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic run(input int limit);
    int n = 0;
    clear_logs();
    pulse_start();
    check("err_clear_on_start", 64'(error), 64'd0);
    while (busy && n < limit) begin @(negedge clk); n++; end
    check("run_timeout", 64'(n < limit), 64'd1);
    @(negedge clk);
  endtask

  task automatic compare(input string tag);
    check({tag, "_ncmd"}, 64'(cmd_log.size()), 64'(exp_cmd.size()));
    for (int j = 0; j < cmd_log.size() && j < exp_cmd.size(); j++) begin
      check({tag, "_op"}, 64'(cmd_log[j][10:8]), 64'(exp_cmd[j][10:8]));
      if (exp_cmd[j][10:8] == 3'd1) check({tag, "_wdata"}, 64'(cmd_log[j][7:0]), 64'(exp_cmd[j][7:0]));
    end
    check({tag, "_nrd"}, 64'(rd_log.size()), 64'(exp_rd.size()));
    for (int j = 0; j < rd_log.size() && j < exp_rd.size(); j++)
      check({tag, "_rd"}, 64'(rd_log[j]), 64'(exp_rd[j]));
    check({tag, "_done"}, 64'(done_cnt), 64'(exp_done));
    check({tag, "_error"}, 64'(error), 64'(exp_err));
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {22'd0, busy, done, error, cmd_valid, cmd_op, cmd_data, rd_valid, rd_idx, rd_data, rom_ce, rom_ad},
          {22'd0, 4'b0000, 3'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, SA});
  endtask

  typedef struct packed {
    logic [5:0][8:0]  prog;
    logic [2:0]       nprog;
    logic [1:0][7:0]  sd;
    logic             nack;
    logic [2:0]       ncmd;
    logic [4:0][10:0] cmd;
    logic [1:0]       nrd;
    logic [1:0][7:0]  rdd;
    logic             done;
    logic             err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vec_t v;
    logic [8:0] prog[$];
    logic [7:0] sd[$];
    int n, b1, b2;
    for (int i = 0; i < 512; i++) rom_mem[i] = 9'h1E0;
    start = 0; hold_low = 0; mute = 0; spurious = 0; nack_cfg = 0;
    clear_logs();
    rst_n = 1; #1 rst_n = 0; #1;
    check_reset_vals("reset_values");
    check("rom_oce", 64'(rom_oce), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1;

    v = '0; v.prog = {9'h0, 9'h100, 9'h140, 9'h0D0, 9'h0EC, 9'h120}; v.nprog = 5;
    v.ncmd = 4; v.cmd = {11'h0, {3'd4, 8'h00}, {3'd1, 8'hD0}, {3'd1, 8'hEC}, {3'd0, 8'h00}};
    v.done = 1; vecs[0] = v;
    v = '0; v.prog = {9'h0, 9'h100, 9'h140, 9'h161, 9'h0ED, 9'h120}; v.nprog = 5;
    v.sd = {8'h5A, 8'h60}; v.ncmd = 5;
    v.cmd = {{3'd4, 8'h00}, {3'd3, 8'h00}, {3'd2, 8'h00}, {3'd1, 8'hED}, {3'd0, 8'h00}};
    v.nrd = 2; v.rdd = {8'h5A, 8'h60}; v.done = 1; vecs[1] = v;
    v = '0; v.prog = {36'h0, 9'h100, 9'h0EC}; v.nprog = 2; v.nack = 1;
`ifdef I2C_SEQ_NACK_ABORT_EN
    v.ncmd = 2; v.cmd = {33'h0, {3'd4, 8'h00}, {3'd1, 8'hEC}}; v.err = 1;
`else
    v.ncmd = 1; v.cmd = {44'h0, {3'd1, 8'hEC}}; v.done = 1;
`endif
    vecs[2] = v;
    v = '0; v.prog = {45'h0, 9'h1C0}; v.nprog = 1; v.ncmd = 1; v.cmd = {44'h0, {3'd4, 8'h00}}; v.err = 1;
    vecs[3] = v;

    for (int t = 0; t < 4; t++) begin
      prog.delete(); slave_q.delete(); exp_cmd.delete(); exp_rd.delete();
      for (int j = 0; j < int'(vecs[t].nprog); j++) prog.push_back(vecs[t].prog[j]);
      for (int j = 0; j < 2; j++) slave_q.push_back(vecs[t].sd[j]);
      for (int j = 0; j < int'(vecs[t].ncmd); j++) exp_cmd.push_back(vecs[t].cmd[j]);
      for (int j = 0; j < int'(vecs[t].nrd); j++) exp_rd.push_back({8'(j), vecs[t].rdd[j]});
      exp_done = vecs[t].done; exp_err = vecs[t].err; nack_cfg = vecs[t].nack;
      load(prog);
      run(500);
      compare($sformatf("vec%0d", t));
    end
    nack_cfg = 0;

    load('{9'h181, 9'h100}); run(500);
    check("wait_busy_cycles", 64'(busy_cyc), 64'd14);
    check("wait_no_cmd", 64'(cmd_log.size()), 64'd0);
    check("wait_done", 64'(done_cnt), 64'd1);
    b1 = busy_cyc;
    load('{9'h183, 9'h100}); run(500); b2 = busy_cyc;
    check("wait_scaling", 64'(b2 - b1), 64'(2 * WU));

    hold_low = 10;
    load('{9'h0EC, 9'h100}); run(500);
    check("stall_stable", 64'(stab_err), 64'd0);
    check("stall_cycles_ge10", 64'(stall_cyc >= 10), 64'd1);
    check("stall_cmd", 64'(cmd_log.size() > 0 ? cmd_log[0] : 11'h7FF), 64'({3'd1, 8'hEC}));
    check("stall_done", 64'(done_cnt), 64'd1);

    sd.delete();
    for (int j = 0; j < 8; j++) sd.push_back(8'($urandom));
    slave_q = sd;
    load('{9'h120, 9'h160, 9'h140, 9'h1A0});
    clear_logs();
    pulse_start();
    n = 0;
    while (rd_log.size() < 1 && n < 500) begin @(negedge clk); n++; end
    pulse_start();
    while (rd_log.size() < 3 && n < 1000) begin @(negedge clk); n++; end
    check("loop_timeout", 64'(n < 1000), 64'd1);
    @(negedge clk); rst_n = 0;
    @(negedge clk); @(negedge clk); rst_n = 1;
    for (int j = 0; j < 3 && j < rd_log.size(); j++)
      check("loop_rd", 64'(rd_log[j]), 64'({8'(j), sd[j]}));
    for (int j = 0; j < 7 && j < cmd_log.size(); j++)
      check("loop_op", 64'(cmd_log[j][10:8]), 64'((j % 3 == 0) ? 3'd0 : (j % 3 == 1) ? 3'd3 : 3'd4));

    spurious = 1;
    for (int t = 0; t < 40; t++) begin
      prog.delete(); sd.delete();
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 4))
          0: prog.push_back({1'b0, 8'($urandom)});
          1: prog.push_back(9'h120);
          2: prog.push_back(9'h140);
          3: prog.push_back(9'h160 | 9'($urandom_range(0, 3)));
          default: prog.push_back(9'h180 | 9'($urandom_range(0, 2)));
        endcase
      end
      if ($urandom_range(0, 9) == 0) prog.push_back(9'h1C0 | 9'($urandom_range(0, 63)));
      prog.push_back(9'h100);
      for (int j = 0; j < 32; j++) sd.push_back(8'($urandom));
      nack_cfg = ($urandom_range(0, 3) == 0);
      slave_q = sd;
      load(prog);
      model(prog, sd, nack_cfg);
      run(3000);
      compare("rnd");
    end
    spurious = 0; nack_cfg = 0;

    mute = 1;
    load('{9'h120, 9'h0EC, 9'h100});
    clear_logs();
    pulse_start();
    n = 0;
    while (cmd_log.size() < 2 && n < 500) begin @(negedge clk); n++; end
    check("rst_wait_timeout", 64'(n < 500), 64'd1);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 0;
    #1 check_reset_vals("reset_mid_wait_rsp");
    repeat (4) @(negedge clk);
    check("reset_no_stop", 64'(cmd_log.size()), 64'd2);
    check("reset_idle", 64'(busy), 64'd0);
    rst_n = 1; mute = 0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bme_i2c_seq.md
BME_I2C_SEQ -- requirements
Module: bme_i2c_seq

Interface
REQ-001 SHALL have parameter START_ADDR, default 9'd0: ROM address of first microcode word.
REQ-002 SHALL have parameter WAIT_UNIT, default 1024: clk cycles per WAIT tick.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begin sequence
- busy  out  1  sequence running
- done  out  1  one-cycle pulse, END executed
- error  out  1  sticky, cleared by next accepted start
- rom_ad  out  9  microcode ROM address
- rom_ce  out  1  ROM clock enable
- rom_oce  out  1  ROM output enable, tied 1
- rom_dout  in  9  ROM word, valid 1 cycle after rom_ad with rom_ce=1
- cmd_valid  out  1  command to I2C byte master
- cmd_ready  in  1  byte master accepts command
- cmd_op  out  3  0 START, 1 WRITE, 2 READ_ACK, 3 READ_NACK, 4 STOP
- cmd_data  out  8  WRITE byte
- rsp_valid  in  1  byte master finished WRITE/READ
- rsp_data  in  8  read byte
- rsp_nack  in  1  slave NACKed a WRITE
- rd_valid  out  1  one-cycle pulse, read byte available
- rd_idx  out  8  read byte index since start, wraps 255->0
- rd_data  out  8  read byte

Function
REQ-004 Word decode: bit8=0 -> WRITE byte [7:0]; bit8=1 -> opcode [7:5], field f=[4:0].
REQ-005 Opcodes: 000 END; 001 START; 010 STOP; 011 READ f+1 bytes; 100 WAIT (f+1)*WAIT_UNIT cycles; 101 LOOP to START_ADDR; 110/111 illegal.
REQ-006 States: IDLE, FETCH, LATCH, DECODE, ISSUE, WAIT_RSP, DELAY, ERR_STOP.
REQ-007 IDLE: start -> rom_ad=START_ADDR, FETCH; start while busy SHALL be ignored.
REQ-008 FETCH drives rom_ce=1 one cycle; LATCH captures rom_dout next cycle (fetch latency 2 cycles); rom_ad increments after capture, wraps 511->0.
REQ-009 ISSUE holds cmd_valid/cmd_op/cmd_data stable until cmd_valid&cmd_ready; START/STOP need no response, go to FETCH.
REQ-010 WRITE/READ go to WAIT_RSP; rsp_valid completes byte; rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-011 READ of n bytes SHALL issue n-1 READ_ACK then one READ_NACK; each rsp_valid pulses rd_valid next cycle with rd_data=rsp_data, rd_idx post-increments.
REQ-012 WAIT: 16-bit down-counter in DELAY, then FETCH; no cmd_valid during DELAY.
REQ-013 END: done pulse one cycle, busy=0, return IDLE; LOOP: rom_ad=START_ADDR, FETCH, rd_idx not reset.
REQ-014 Illegal opcode: error=1, issue STOP via ERR_STOP, then IDLE without done.
REQ-015 busy=1 in every state except IDLE.

Reset
REQ-016 rst_n low SHALL force IDLE asynchronously, even mid-transaction; no STOP issued.
REQ-017 Reset values: busy=0, done=0, error=0, cmd_valid=0, cmd_op=0, cmd_data=0, rd_valid=0, rd_idx=0, rd_data=0, rom_ce=0, rom_ad=START_ADDR.
REQ-018 rd_idx SHALL also clear to 0 on each accepted start.

Configuration
REQ-019 Macro I2C_SEQ_NACK_ABORT_EN defined: rsp_nack with WRITE response -> error=1, ERR_STOP, IDLE, no done.
REQ-020 Macro undefined: rsp_nack ignored, sequence continues, error set only by illegal opcode.

Verification
REQ-021 ROM 0x120,0x0EC,0x0D0,0x140,0x100; start -> cmd ops START,WRITE EC,WRITE D0,STOP; done pulse once; error=0.
REQ-022 ROM 0x120,0x0ED,0x161,0x140,0x100; slave bytes 0x60,0x5A -> READ_ACK then READ_NACK; rd_valid x2 idx 0,1 data 0x60,0x5A.
REQ-023 WAIT_UNIT=4, ROM 0x181,0x100 -> 8 cycles in DELAY, done thereafter; cmd_ready held low 10 cycles on a WRITE -> cmd_valid/cmd_data stable throughout.
REQ-024 ROM 0x0EC with rsp_nack=1, then 0x100 -> with macro: error=1, STOP issued, no done; without: done, error=0.
REQ-025 ROM 0x1C0 -> error=1, STOP, IDLE; rst_n low during WAIT_RSP -> all outputs at reset values same cycle.
